// File: rtl/sign_addsub_arbiter.sv
// sign_addsub_arbiter: round-robin sequencer sharing one external registered
// signed add/sub unit (1-cycle latency) among NUM_REQ requesters.
// Sequence per operation: IDLE (grant) -> EXEC -> WAIT (capture) -> RESP.
// Optional build macro SIGN_ADD_SUB_ARBITER_SAT_EN adds RespOverflow and
// clamps overflowing results to the signed extreme matching operand A.
module sign_addsub_arbiter #(
    parameter int unsigned INPUT_BIT_WIDTH = 8,
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ID_WIDTH        = 2
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic [NUM_REQ-1:0]                   ReqValid,
    input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0]   ReqA,
    input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0]   ReqB,
    input  logic [NUM_REQ-1:0]                   ReqMode,
    output logic [NUM_REQ-1:0]                   ReqReady,
    output logic [INPUT_BIT_WIDTH-1:0]           UnitA,
    output logic [INPUT_BIT_WIDTH-1:0]           UnitB,
    output logic                                 UnitMode,
    input  logic [INPUT_BIT_WIDTH-1:0]           UnitResult,
    output logic                                 RespValid,
    input  logic                                 RespReady,
    output logic [ID_WIDTH-1:0]                  RespId,
    output logic [INPUT_BIT_WIDTH-1:0]           RespData,
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
    output logic                                 RespOverflow,
`endif
    output logic                                 Busy
);

    localparam int unsigned W     = INPUT_BIT_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [W-1:0]       unit_a_q, unit_a_d;
    logic [W-1:0]       unit_b_q, unit_b_d;
    logic               unit_mode_q, unit_mode_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;
    logic [W-1:0]       resp_data_q, resp_data_d;

    logic               grant_found_c;
    logic [IDX_W-1:0]   grant_idx_c;

`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic               ovf_q, ovf_d;
    logic               ovf_c;
    logic [W-1:0]       sat_c;

    // Signed overflow detect on the operands currently held at the unit.
    always_comb begin
        ovf_c = 1'b0;
        sat_c = unit_a_q[W-1] ? SAT_MIN : SAT_MAX;
        if (unit_mode_q) begin
            ovf_c = (unit_a_q[W-1] == unit_b_q[W-1]) && (UnitResult[W-1] != unit_a_q[W-1]);
        end else begin
            ovf_c = (unit_a_q[W-1] != unit_b_q[W-1]) && (UnitResult[W-1] != unit_a_q[W-1]);
        end
    end
`endif

    // Rotating-priority search: first valid requester at or above the pointer.
    always_comb begin : grant_search
        int unsigned cand;
        cand          = 0;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found_c && ReqValid[IDX_W'(cand)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = IDX_W'(cand);
            end
        end
    end

    // One-hot accept, only offered in IDLE and never while reset is asserted.
    always_comb begin
        ReqReady = '0;
        if ((state_q == ST_IDLE) && grant_found_c && !Reset) begin
            ReqReady[grant_idx_c] = 1'b1;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_mode_d  = unit_mode_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found_c) begin
                    unit_a_d    = ReqA[32'(grant_idx_c)*W +: W];
                    unit_b_d    = ReqB[32'(grant_idx_c)*W +: W];
                    unit_mode_d = ReqMode[grant_idx_c];
                    id_d        = ID_WIDTH'(grant_idx_c);
                    ptr_d       = (32'(grant_idx_c) == NUM_REQ - 1) ? '0
                                                                   : grant_idx_c + IDX_W'(1);
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_data_d  = UnitResult;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
                ovf_d        = ovf_c;
                if (ovf_c) begin
                    resp_data_d = sat_c;
                end
`endif
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (RespReady) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_mode_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_mode_q  <= unit_mode_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign UnitA     = unit_a_q;
    assign UnitB     = unit_b_q;
    assign UnitMode  = unit_mode_q;
    assign RespValid = resp_valid_q;
    assign RespId    = resp_id_q;
    assign RespData  = resp_data_q;
    assign Busy      = (state_q != ST_IDLE);
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
    assign RespOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_sign_addsub_arbiter.sv
// Directed bench for sign_addsub_arbiter with a behavioural registered add/sub unit.
module tb_sign_addsub_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic             Clk;
    logic             Reset;
    logic [N-1:0]     ReqValid;
    logic [N*W-1:0]   ReqA;
    logic [N*W-1:0]   ReqB;
    logic [N-1:0]     ReqMode;
    logic [N-1:0]     ReqReady;
    logic [W-1:0]     UnitA;
    logic [W-1:0]     UnitB;
    logic             UnitMode;
    logic [W-1:0]     UnitResult;
    logic             RespValid;
    logic             RespReady;
    logic [1:0]       RespId;
    logic [W-1:0]     RespData;
    logic             Busy;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
    logic             RespOverflow;
`endif

    int checks = 0;
    int errors = 0;

    sign_addsub_arbiter #(.INPUT_BIT_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(2)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
        .ReqMode(ReqMode), .ReqReady(ReqReady), .UnitA(UnitA), .UnitB(UnitB),
        .UnitMode(UnitMode), .UnitResult(UnitResult), .RespValid(RespValid),
        .RespReady(RespReady), .RespId(RespId), .RespData(RespData),
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
        .RespOverflow(RespOverflow),
`endif
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // External unit: samples operands on the edge, result valid after it.
    always @(posedge Clk) begin
        UnitResult <= UnitMode ? (UnitA + UnitB) : (UnitA - UnitB);
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mode);
        ReqA[idx*W +: W] = a;
        ReqB[idx*W +: W] = b;
        ReqMode[idx]     = mode;
    endtask

    task automatic test_reset;
        Reset = 1'b1; RespReady = 1'b1; ReqValid = 4'b1111;
        ReqA = '0; ReqB = '0; ReqMode = '0;
        tick; tick;
        checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ReqReady); end
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", RespValid); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (RespData !== 8'h00 || RespId !== 2'd0) begin errors++; $display("FAIL reset_resp got %h/%0d exp 00/0", RespData, RespId); end
        checks++; if (UnitA !== 8'h00 || UnitB !== 8'h00 || UnitMode !== 1'b0) begin errors++; $display("FAIL reset_unit got %h %h %b exp 00 00 0", UnitA, UnitB, UnitMode); end
        ReqValid = '0;
        Reset = 1'b0;
    endtask

    task automatic test_single_add;
        set_req(0, 8'd5, 8'hFD, 1'b1);
        ReqValid = 4'b0001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", ReqReady); end
        tick;
        ReqValid = '0;
        checks++; if (ReqReady !== 4'b0000 || Busy !== 1'b1) begin errors++; $display("FAIL single_exec got %b/%b exp 0000/1", ReqReady, Busy); end
        checks++; if (UnitA !== 8'd5 || UnitB !== 8'hFD || UnitMode !== 1'b1) begin errors++; $display("FAIL single_unit got %h %h %b exp 05 fd 1", UnitA, UnitB, UnitMode); end
        tick;
        checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", RespValid); end
        tick;
        checks++; if (RespValid !== 1'b1 || RespData !== 8'd2 || RespId !== 2'd0) begin errors++; $display("FAIL single_resp got %b %h %0d exp 1 02 0", RespValid, RespData, RespId); end
        tick;
        checks++; if (RespValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL single_done got %b/%b exp 0/0", RespValid, Busy); end
    endtask

    task automatic test_rotation;
        logic [1:0]   exp_id [5];
        logic [W-1:0] exp_d  [5];
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d  = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'hFF};
        Reset = 1'b1; tick; Reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, W'(i), 8'd1, 1'b0);
        ReqValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (ReqReady !== (4'b0001 << exp_id[k])) begin errors++; $display("FAIL rot_grant%0d got %b exp id %0d", k, ReqReady, exp_id[k]); end
            tick; tick; tick;
            checks++; if (RespValid !== 1'b1 || RespId !== exp_id[k] || RespData !== exp_d[k]) begin errors++; $display("FAIL rot_resp%0d got %b %0d %h exp 1 %0d %h", k, RespValid, RespId, RespData, exp_id[k], exp_d[k]); end
            tick;
        end
        ReqValid = '0;
    endtask

    task automatic test_sub_wrap;
        set_req(2, 8'h80, 8'd1, 1'b0);
        ReqValid = 4'b0100;
        #1;
        checks++; if (ReqReady !== 4'b0100) begin errors++; $display("FAIL wrap_grant got %b exp 0100", ReqReady); end
        tick;
        ReqValid = '0;
        tick; tick;
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
        checks++; if (RespData !== 8'h80 || RespId !== 2'd2) begin errors++; $display("FAIL wrap_sat got %h/%0d exp 80/2", RespData, RespId); end
        checks++; if (RespOverflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", RespOverflow); end
`else
        checks++; if (RespData !== 8'h7F || RespId !== 2'd2) begin errors++; $display("FAIL wrap_data got %h/%0d exp 7f/2", RespData, RespId); end
`endif
        tick;
    endtask

    task automatic test_backpressure;
        set_req(1, 8'd100, 8'd27, 1'b1);
        ReqValid = 4'b0010;
        RespReady = 1'b0;
        #1;
        checks++; if (ReqReady !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b exp 0010", ReqReady); end
        tick; tick; tick;
        for (int k = 0; k < 5; k++) begin
            checks++; if (RespValid !== 1'b1 || RespId !== 2'd1 || RespData !== 8'd127) begin errors++; $display("FAIL bp_hold%0d got %b %0d %h exp 1 1 7f", k, RespValid, RespId, RespData); end
            checks++; if (ReqReady !== 4'b0000 || Busy !== 1'b1) begin errors++; $display("FAIL bp_busy%0d got %b/%b exp 0000/1", k, ReqReady, Busy); end
`ifdef SIGN_ADD_SUB_ARBITER_SAT_EN
            checks++; if (RespOverflow !== 1'b0) begin errors++; $display("FAIL bp_ovf%0d got %b exp 0", k, RespOverflow); end
`endif
            tick;
        end
        RespReady = 1'b1;
        #1;
        checks++; if (RespValid !== 1'b1) begin errors++; $display("FAIL bp_last got %b exp 1", RespValid); end
        tick;
        checks++; if (Busy !== 1'b0 || RespValid !== 1'b0 || ReqReady !== 4'b0010) begin errors++; $display("FAIL bp_idle got %b %b %b exp 0 0 0010", Busy, RespValid, ReqReady); end
        ReqValid = '0;
    endtask

    task automatic test_reset_mid;
        // Pointer sits at 2 here; granting req1 keeps it at 2 so reset must restore 0.
        set_req(1, 8'd9, 8'd9, 1'b1);
        ReqValid = 4'b0010;
        #1;
        checks++; if (ReqReady !== 4'b0010) begin errors++; $display("FAIL rmid_grant got %b exp 0010", ReqReady); end
        tick;
        ReqValid = '0;
        tick;
        Reset = 1'b1;
        set_req(0, 8'd3, 8'd4, 1'b1);
        set_req(3, 8'd20, 8'd1, 1'b1);
        ReqValid = 4'b1001;
        #1;
        checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL rmid_rst_ready got %b exp 0000", ReqReady); end
        tick;
        Reset = 1'b0;
        checks++; if (RespValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b/%b exp 0/0", RespValid, Busy); end
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL rmid_ptr got %b exp 0001", ReqReady); end
        tick;
        ReqValid = '0;
        tick; tick;
        checks++; if (RespValid !== 1'b1 || RespId !== 2'd0 || RespData !== 8'd7) begin errors++; $display("FAIL rmid_resp got %b %0d %h exp 1 0 07", RespValid, RespId, RespData); end
        tick;
    endtask

    task automatic test_ptr_wrap;
        set_req(3, 8'd10, 8'd3, 1'b0);
        ReqValid = 4'b1000;
        #1;
        checks++; if (ReqReady !== 4'b1000) begin errors++; $display("FAIL pw_grant3 got %b exp 1000", ReqReady); end
        tick;
        ReqValid = '0;
        tick; tick;
        checks++; if (RespId !== 2'd3 || RespData !== 8'd7) begin errors++; $display("FAIL pw_resp3 got %0d %h exp 3 07", RespId, RespData); end
        tick;
        set_req(0, 8'hFE, 8'hFD, 1'b1);
        ReqValid = 4'b1001;
        #1;
        checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL pw_grant0 got %b exp 0001", ReqReady); end
        tick;
        ReqValid = '0;
        tick; tick;
        checks++; if (RespId !== 2'd0 || RespData !== 8'hFB) begin errors++; $display("FAIL pw_resp0 got %0d %h exp 0 fb", RespId, RespData); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_add;
        test_rotation;
        test_sub_wrap;
        test_backpressure;
        test_reset_mid;
        test_ptr_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
